// File: rtl/traffic_request_ctrl.sv
// traffic_request_ctrl
//
// Input conditioner and request arbiter placed upstream of the traffic light
// controller.
//
// Each raw input goes through a 2-flop synchroniser and then an 8-bit debounce
// counter. The stable values feed two state machines:
//   - pedestrian FSM: latches a button press until the lamps show red, and
//     counts served requests;
//   - emergency FSM: forces red while the detector is active, then holds
//     red for HOLD_CYCLES more cycles.
//
// Optional feature: define TRAFFIC_REQ_COOLDOWN_EN to add a COOLDOWN state.
// It enforces a COOLDOWN_CYCLES gap after a served pedestrian request.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   ped_btn_raw  in   raw pedestrian button (asynchronous)
//   emerg_raw    in   raw emergency-vehicle detector (asynchronous)
//   pref_sw_raw  in   raw preferential-route switch (asynchronous)
//   leds_in      in   [0:2] controller lamp feedback, 3'b001 = red
//   attention    out  pedestrian request pending
//   force_red    out  emergency override
//   preferential out  debounced preferential switch level
//   ped_wait     out  WAIT lamp, same as attention
//   req_count    out  [7:0] served pedestrian requests, saturating at 255
module traffic_request_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int COOLDOWN_CYCLES = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_btn_raw,
    input  logic       emerg_raw,
    input  logic       pref_sw_raw,
    input  logic [0:2] leds_in,
    output logic       attention,
    output logic       force_red,
    output logic       preferential,
    output logic       ped_wait,
    output logic [7:0] req_count
);

    localparam logic [7:0] DEB_LIM  = 8'(DEBOUNCE_CYCLES);
    localparam logic [7:0] HOLD_LIM = 8'(HOLD_CYCLES);

    // Reject out-of-range configurations at elaboration time.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be 1..255");
    end
    if (HOLD_CYCLES < 0 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("HOLD_CYCLES must be 0..255");
    end
    if (COOLDOWN_CYCLES < 1 || COOLDOWN_CYCLES > 255) begin : g_bad_cooldown
        $error("COOLDOWN_CYCLES must be 1..255");
    end

`ifdef TRAFFIC_REQ_COOLDOWN_EN
    localparam logic [7:0] COOL_LIM = 8'(COOLDOWN_CYCLES);
    typedef enum logic [1:0] {
        PED_IDLE     = 2'd0,
        PED_PENDING  = 2'd1,
        PED_SERVING  = 2'd2,
        PED_COOLDOWN = 2'd3
    } ped_state_t;
    logic [7:0] cool_cnt;
`else
    typedef enum logic [1:0] {
        PED_IDLE    = 2'd0,
        PED_PENDING = 2'd1,
        PED_SERVING = 2'd2
    } ped_state_t;
`endif

    typedef enum logic [1:0] {
        EM_NORMAL = 2'd0,
        EM_FORCE  = 2'd1,
        EM_HOLD   = 2'd2
    } em_state_t;

    // Bit 0 = pedestrian button, bit 1 = emergency, bit 2 = preferential switch.
    logic [2:0] raw;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] stable;
    logic [7:0] dcnt [3];

    logic       btn_prev;
    logic       btn_rise;
    logic       led_red;
    logic       pref_reg;
    logic [7:0] hold_cnt;
    ped_state_t ped_state;
    em_state_t  em_state;

    assign raw      = {pref_sw_raw, emerg_raw, ped_btn_raw};
    assign btn_rise = stable[0] & ~btn_prev;
    assign led_red  = (leds_in == 3'b001);

    // Synchronise the raw inputs and debounce each synchronised bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1  <= 3'b000;
            sync2  <= 3'b000;
            stable <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                dcnt[i] <= 8'd0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == stable[i]) begin
                    dcnt[i] <= 8'd0;
                end else if (dcnt[i] + 8'd1 == DEB_LIM) begin
                    // The difference has persisted long enough: accept the new level.
                    stable[i] <= sync2[i];
                    dcnt[i]   <= 8'd0;
                end else begin
                    dcnt[i] <= dcnt[i] + 8'd1;
                end
            end
        end
    end

    // Pedestrian request FSM and served-request counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ped_state <= PED_IDLE;
            req_count <= 8'd0;
            btn_prev  <= 1'b0;
`ifdef TRAFFIC_REQ_COOLDOWN_EN
            cool_cnt  <= 8'd0;
`endif
        end else begin
            btn_prev <= stable[0];
            case (ped_state)
                PED_IDLE: begin
                    // Edges seen in any other state are dropped, not queued.
                    if (btn_rise) begin
                        ped_state <= PED_PENDING;
                    end else begin
                        ped_state <= PED_IDLE;
                    end
                end
                PED_PENDING: begin
                    // Any red serves the request, including red forced by an emergency.
                    if (led_red) begin
                        ped_state <= PED_SERVING;
                        if (req_count != 8'hFF) begin
                            req_count <= req_count + 8'd1;
                        end else begin
                            req_count <= req_count;
                        end
                    end else begin
                        ped_state <= PED_PENDING;
                    end
                end
                PED_SERVING: begin
                    if (!led_red) begin
`ifdef TRAFFIC_REQ_COOLDOWN_EN
                        ped_state <= PED_COOLDOWN;
                        cool_cnt  <= COOL_LIM;
`else
                        ped_state <= PED_IDLE;
`endif
                    end else begin
                        ped_state <= PED_SERVING;
                    end
                end
`ifdef TRAFFIC_REQ_COOLDOWN_EN
                PED_COOLDOWN: begin
                    if (cool_cnt <= 8'd1) begin
                        ped_state <= PED_IDLE;
                        cool_cnt  <= 8'd0;
                    end else begin
                        cool_cnt <= cool_cnt - 8'd1;
                    end
                end
`endif
                default: begin
                    ped_state <= PED_IDLE;
                end
            endcase
        end
    end

    // Emergency override FSM with post-emergency hold time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            em_state <= EM_NORMAL;
            hold_cnt <= 8'd0;
        end else begin
            case (em_state)
                EM_NORMAL: begin
                    if (stable[1]) begin
                        em_state <= EM_FORCE;
                    end else begin
                        em_state <= EM_NORMAL;
                    end
                end
                EM_FORCE: begin
                    if (stable[1]) begin
                        em_state <= EM_FORCE;
                    end else if (HOLD_LIM == 8'd0) begin
                        em_state <= EM_NORMAL;
                    end else begin
                        em_state <= EM_HOLD;
                        hold_cnt <= HOLD_LIM;
                    end
                end
                EM_HOLD: begin
                    // A renewed emergency cancels the hold and returns to FORCE.
                    if (stable[1]) begin
                        em_state <= EM_FORCE;
                    end else if (hold_cnt == 8'd1) begin
                        em_state <= EM_NORMAL;
                        hold_cnt <= 8'd0;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                default: begin
                    em_state <= EM_NORMAL;
                    hold_cnt <= 8'd0;
                end
            endcase
        end
    end

    // Register the debounced preferential switch level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pref_reg <= 1'b0;
        end else begin
            pref_reg <= stable[2];
        end
    end

    assign attention    = (ped_state == PED_PENDING);
    assign ped_wait     = (ped_state == PED_PENDING);
    assign force_red    = (em_state == EM_FORCE) || (em_state == EM_HOLD);
    assign preferential = pref_reg;

endmodule

// File: tb/tb_traffic_request_ctrl.sv
// Directed testbench for traffic_request_ctrl (D=4, H=8, C=20).
module tb_traffic_request_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ped_btn_raw = 1'b0;
    logic       emerg_raw = 1'b0;
    logic       pref_sw_raw = 1'b0;
    logic [0:2] leds_in = 3'b000;
    logic       attention;
    logic       force_red;
    logic       preferential;
    logic       ped_wait;
    logic [7:0] req_count;

    int errors = 0;
    int checks = 0;

    traffic_request_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(8),
        .COOLDOWN_CYCLES(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ped_btn_raw(ped_btn_raw),
        .emerg_raw(emerg_raw),
        .pref_sw_raw(pref_sw_raw),
        .leds_in(leds_in),
        .attention(attention),
        .force_red(force_red),
        .preferential(preferential),
        .ped_wait(ped_wait),
        .req_count(req_count)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; samples are taken 1 time unit later.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #2;
        checks++;
        if ({attention, force_red, preferential, ped_wait, req_count} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got att=%b fr=%b pref=%b wait=%b cnt=%0d, need all 0",
                     attention, force_red, preferential, ped_wait, req_count);
        end
        tick(2);
        rst = 1'b1;
        tick(3);
        checks++;
        if ({attention, force_red, preferential, req_count} !== 11'h000) begin
            errors++;
            $display("FAIL reset_idle: got att=%b fr=%b pref=%b cnt=%0d, need all 0",
                     attention, force_red, preferential, req_count);
        end
    endtask

    // Press from edge 0: attention after edge 6; red sampled at edge 21 serves it.
    task automatic test_ped_request;
        ped_btn_raw = 1'b1;
        tick(6);
        checks++;
        if (attention !== 1'b0) begin
            errors++;
            $display("FAIL ped_early: attention=%b after edge 5, need 0", attention);
        end
        tick(1);
        checks++;
        if (attention !== 1'b1 || ped_wait !== 1'b1) begin
            errors++;
            $display("FAIL ped_rise: att=%b wait=%b after edge 6, need 1/1", attention, ped_wait);
        end
        tick(14);
        leds_in = 3'b001;
        checks++;
        if (attention !== 1'b1) begin
            errors++;
            $display("FAIL ped_latched: attention=%b after edge 20, need 1", attention);
        end
        tick(1);
        checks++;
        if (attention !== 1'b0 || ped_wait !== 1'b0 || req_count !== 8'd1) begin
            errors++;
            $display("FAIL ped_served: att=%b wait=%b cnt=%0d, need 0/0/1", attention, ped_wait, req_count);
        end
        leds_in = 3'b000;
        ped_btn_raw = 1'b0;
        tick(12);
    endtask

    // 3-cycle pulse is shorter than the debounce window.
    task automatic test_glitch;
        int seen;
        seen = 0;
        ped_btn_raw = 1'b1;
        tick(3);
        ped_btn_raw = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (attention !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0 || req_count !== 8'd1) begin
            errors++;
            $display("FAIL glitch: attention high %0d cycles, cnt=%0d, need 0 and 1", seen, req_count);
        end
    endtask

    task automatic test_emergency;
        int drops;
        emerg_raw = 1'b1;
        pref_sw_raw = 1'b1;
        tick(6);
        checks++;
        if (force_red !== 1'b0 || preferential !== 1'b0) begin
            errors++;
            $display("FAIL emerg_early: fr=%b pref=%b after edge 5, need 0/0", force_red, preferential);
        end
        tick(1);
        checks++;
        if (force_red !== 1'b1 || preferential !== 1'b1) begin
            errors++;
            $display("FAIL emerg_rise: fr=%b pref=%b after edge 6, need 1/1", force_red, preferential);
        end
        // Raw high edges 0..19; stable falls after edge 25; force_red drops after edge 34.
        tick(13);
        emerg_raw = 1'b0;
        drops = 0;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            if (force_red !== 1'b1) drops++;
        end
        checks++;
        if (drops != 0) begin
            errors++;
            $display("FAIL emerg_hold: force_red low %0d times through edge 33, need 0", drops);
        end
        tick(1);
        checks++;
        if (force_red !== 1'b0) begin
            errors++;
            $display("FAIL emerg_fall: force_red=%b after edge 34, need 0", force_red);
        end
        // Second episode: re-assert raw right after the stable value falls (in HOLD).
        emerg_raw = 1'b1;
        tick(20);
        emerg_raw = 1'b0;
        tick(6);
        emerg_raw = 1'b1;
        drops = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (force_red !== 1'b1) drops++;
        end
        checks++;
        if (drops != 0) begin
            errors++;
            $display("FAIL emerg_reassert: force_red low %0d times, need 0", drops);
        end
        emerg_raw = 1'b0;
        pref_sw_raw = 1'b0;
        tick(25);
        checks++;
        if (force_red !== 1'b0 || preferential !== 1'b0) begin
            errors++;
            $display("FAIL emerg_clear: fr=%b pref=%b, need 0/0", force_red, preferential);
        end
    endtask

    // Second press while PENDING must not queue a further request.
    task automatic test_back_to_back;
        ped_btn_raw = 1'b1;
        tick(7);
        ped_btn_raw = 1'b0;
        tick(8);
        ped_btn_raw = 1'b1;
        tick(10);
        leds_in = 3'b001;
        tick(1);
        leds_in = 3'b000;
        ped_btn_raw = 1'b0;
        tick(15);
        checks++;
        if (req_count !== 8'd2 || attention !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back: cnt=%0d att=%b, need 2/0", req_count, attention);
        end
    endtask

    task automatic serve_one;
        ped_btn_raw = 1'b1;
        tick(7);
        ped_btn_raw = 1'b0;
        leds_in = 3'b001;
        tick(1);
        leds_in = 3'b000;
        tick(8);
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 253; i++) serve_one();
        checks++;
        if (req_count !== 8'd255) begin
            errors++;
            $display("FAIL sat_reach: cnt=%0d, need 255", req_count);
        end
        serve_one();
        checks++;
        if (req_count !== 8'd255) begin
            errors++;
            $display("FAIL sat_hold: cnt=%0d, need 255", req_count);
        end
    endtask

    task automatic test_async_reset;
        ped_btn_raw = 1'b1;
        emerg_raw = 1'b1;
        tick(7);
        checks++;
        if (attention !== 1'b1 || force_red !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: att=%b fr=%b, need 1/1", attention, force_red);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({attention, force_red, preferential, ped_wait, req_count} !== 12'h000) begin
            errors++;
            $display("FAIL async_reset: att=%b fr=%b pref=%b wait=%b cnt=%0d, need all 0",
                     attention, force_red, preferential, ped_wait, req_count);
        end
        tick(2);
        rst = 1'b1;
        tick(6);
        checks++;
        if (attention !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_early: attention=%b after edge 5, need 0", attention);
        end
        tick(1);
        checks++;
        if (attention !== 1'b1 || force_red !== 1'b1 || req_count !== 8'd0) begin
            errors++;
            $display("FAIL post_reset_press: att=%b fr=%b cnt=%0d, need 1/1/0", attention, force_red, req_count);
        end
        ped_btn_raw = 1'b0;
        emerg_raw = 1'b0;
        leds_in = 3'b001;
        tick(1);
        leds_in = 3'b000;
        tick(25);
    endtask

`ifdef TRAFFIC_REQ_COOLDOWN_EN
    task automatic test_cooldown;
        int seen;
        logic [7:0] base;
        base = req_count;
        ped_btn_raw = 1'b1;
        tick(7);
        ped_btn_raw = 1'b0;
        leds_in = 3'b001;
        tick(2);
        leds_in = 3'b000;
        tick(1);
        // Press during cooldown: its debounced edge lands inside the window.
        ped_btn_raw = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (attention !== 1'b0) seen++;
        end
        ped_btn_raw = 1'b0;
        tick(25);
        checks++;
        if (seen != 0 || attention !== 1'b0) begin
            errors++;
            $display("FAIL cooldown_ignore: attention high %0d cycles, need 0", seen);
        end
        ped_btn_raw = 1'b1;
        tick(7);
        checks++;
        if (attention !== 1'b1 || req_count !== base + 8'd1) begin
            errors++;
            $display("FAIL cooldown_after: att=%b cnt=%0d, need 1/%0d", attention, req_count, base + 8'd1);
        end
        ped_btn_raw = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_ped_request();
        test_glitch();
        test_emergency();
        test_back_to_back();
        test_saturation();
        test_async_reset();
`ifdef TRAFFIC_REQ_COOLDOWN_EN
        test_cooldown();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_request_ctrl.md
# traffic_request_ctrl

Input conditioner and request arbiter that sits directly upstream of the traffic light controller. It synchronises and debounces the raw pedestrian button, emergency-vehicle and preferential-route switch inputs. From those it generates the controller's `attention`, `force_red` and `preferential` inputs. Pedestrian requests stay latched until the controller's `leds` feedback shows red, and a served-request count is kept for the maintenance panel.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive cycles a synchronised input must differ from its stable value before the stable value changes; must be 1..255.
- `HOLD_CYCLES`, 8: cycles `force_red` stays high after the debounced emergency input drops; 0..255.
- `COOLDOWN_CYCLES`, 20: minimum gap after a served pedestrian request; used only with `TRAFFIC_REQ_COOLDOWN_EN`; 1..255.
- `clk  in  1`: clock, rising edge.
- `rst  in  1`: reset, asynchronous, active-low.
- `ped_btn_raw  in  1`: raw pedestrian button, asynchronous.
- `emerg_raw  in  1`: raw emergency-vehicle detector, asynchronous.
- `pref_sw_raw  in  1`: raw preferential-route switch, asynchronous.
- `leds_in  in  [0:2]`: controller lamp feedback; 3'b001 means red.
- `attention  out  1`: pedestrian request pending, to controller.
- `force_red  out  1`: emergency override, to controller.
- `preferential  out  1`: debounced switch level, to controller.
- `ped_wait  out  1`: "WAIT" lamp; equals `attention`.
- `req_count  out  8`: served pedestrian requests, saturating at 255.

## Operation
- **Input path, per raw input.** Each raw input passes through a 2-flop synchroniser. An 8-bit debounce counter follows.
  - The counter clears whenever the synchronised value equals the stable value.
  - The counter increments when the two differ.
  - When it would reach `DEBOUNCE_CYCLES`, the stable value takes the synchronised value and the counter clears.
- **`preferential`** is the stable switch value, registered.
- **Pedestrian FSM:**
  - IDLE → PENDING on a rising edge of the stable button value.
  - PENDING drives `attention`=`ped_wait`=1.
  - PENDING → SERVING on the first cycle `leds_in`==3'b001. On that transition `req_count` increments, saturating at 255.
  - SERVING drives `attention`=0.
  - SERVING → IDLE on the first cycle `leds_in`!=3'b001.
  - Button edges in PENDING and SERVING are discarded, not queued.
  - Red caused by `force_red` also serves a pending request.
- **Emergency FSM:**
  - NORMAL → FORCE on stable emergency high.
  - FORCE → HOLD on stable emergency low, loading the hold counter with `HOLD_CYCLES`. If `HOLD_CYCLES`==0, FORCE → NORMAL directly.
  - HOLD decrements the counter and goes → NORMAL when the counter is 1.
  - Stable emergency high in HOLD → FORCE.
  - `force_red`=1 in FORCE and HOLD.
- **Independence:** the two FSMs are independent. `attention` and `force_red` may be high together; the controller gives `force_red` priority.
- **Outputs** are Moore decodes of registered state, with no combinational path from any input.
- **Reset:** everything clears to 0, including all outputs, synchronisers, stable values, counters and FSMs (IDLE, NORMAL). A button held across reset release is treated as a new press.

## Timing
- **Raw-to-output latency.** Raw held high from edge 0 gives:
  - stable value high after edge `DEBOUNCE_CYCLES`+1;
  - `attention`/`force_red` high after edge `DEBOUNCE_CYCLES`+2;
  - `preferential` high after edge `DEBOUNCE_CYCLES`+2.
- **Glitch rejection:** a glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles never changes a stable value.
- **`attention` fall:** drops one edge after the edge that samples `leds_in`==3'b001.
- **`req_count` update:** increments on that same edge.
- **`force_red` fall:** drops `HOLD_CYCLES`+1 edges after the stable emergency value falls.

## Configuration
- **`TRAFFIC_REQ_COOLDOWN_EN` defined:**
  - SERVING → COOLDOWN instead of IDLE.
  - COOLDOWN counts `COOLDOWN_CYCLES` cycles, then → IDLE.
  - Button edges during COOLDOWN are discarded; `attention`=0.
- **Undefined:** the COOLDOWN state and its counter are absent.

## Test plan
- Reset, then `ped_btn_raw`=1 from edge 0 with D=4 → `attention`=`ped_wait`=1 after edge 6; `leds_in`=001 at edge 20 → `attention`=0 after edge 21, `req_count`=1.
- 3-cycle button pulse with D=4 → `attention` stays 0, `req_count` unchanged.
- `emerg_raw` high for 20 cycles then low, H=8 → `force_red` rises after edge 6 and stays high 9 edges after the stable value falls; re-assert during HOLD → stays high continuously.
- `req_count` preset by 255 served requests, one more request served → stays 255; second press while PENDING → exactly one increment.
- Assert `rst`=0 mid-PENDING with `force_red`=1 → all outputs 0 immediately (asynchronous); button still held after release → new `attention` after D+2 edges.
- With `TRAFFIC_REQ_COOLDOWN_EN`, C=20: press within 20 cycles after red ends → ignored; press after cooldown → `attention` asserted.
